// File: rtl/rc_pkg.sv
// Shared definitions for the partial-reconfiguration scheduler: engine register map,
// status bit positions, AXI response code and the scheduler FSM state type.
package rc_pkg;

  localparam logic [7:0] RC_CTRL   = 8'h00;
  localparam logic [7:0] RC_ADDR   = 8'h08;
  localparam logic [7:0] RC_LEN    = 8'h10;
  localparam logic [7:0] RC_STATUS = 8'h18;

  localparam int unsigned RC_ST_BUSY  = 0;
  localparam int unsigned RC_ST_DONE  = 1;
  localparam int unsigned RC_ST_ERROR = 2;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [3:0] {
    StIdle,
    StArb,
    StDecpl,
    StWrAddr,
    StWrLen,
    StWrStart,
    StPollWait,
    StPollRd,
    StFinish,
    StFail
  } rc_sched_state_t;

endpackage

// File: rtl/rc_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above pointer p_i,
// wrapping modulo N.
module rc_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] p_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IdxW'((32'(p_i) + k) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rc_scheduler.sv
// Shares one partial-reconfiguration engine between N_REQ partitions: round-robin grant,
// AXI4-Lite programming of ADDR/LEN/CTRL, status polling with timeout, per-partition decouple.
module rc_scheduler
  import rc_pkg::*;
#(
  parameter int unsigned N_REQ               = 4,
  parameter int unsigned C_M_AXIL_ADDR_WIDTH = 5,
  parameter int unsigned C_M_AXIL_DATA_WIDTH = 64,
  parameter int unsigned BS_LENGTH_BITS      = 24,
  parameter int unsigned POLL_INTERVAL       = 64,
  parameter int unsigned TIMEOUT_CYCLES      = 2**24
) (
  input  logic                               AXI_aclk,
  input  logic                               AXI_areset,
  input  logic [N_REQ-1:0]                   req,
  input  logic [N_REQ*32-1:0]                req_addr,
  input  logic [N_REQ*BS_LENGTH_BITS-1:0]    req_len,
  output logic [N_REQ-1:0]                   ack,
  output logic [N_REQ-1:0]                   err,
  output logic                               busy,
  output logic [N_REQ-1:0]                   decouple_rp,
  output logic [C_M_AXIL_ADDR_WIDTH-1:0]     m_axil_awaddr,
  output logic [2:0]                         m_axil_awprot,
  output logic                               m_axil_awvalid,
  input  logic                               m_axil_awready,
  output logic [C_M_AXIL_DATA_WIDTH-1:0]     m_axil_wdata,
  output logic [C_M_AXIL_DATA_WIDTH/8-1:0]   m_axil_wstrb,
  output logic                               m_axil_wvalid,
  input  logic                               m_axil_wready,
  input  logic [1:0]                         m_axil_bresp,
  input  logic                               m_axil_bvalid,
  output logic                               m_axil_bready,
  output logic [C_M_AXIL_ADDR_WIDTH-1:0]     m_axil_araddr,
  output logic [2:0]                         m_axil_arprot,
  output logic                               m_axil_arvalid,
  input  logic                               m_axil_arready,
  input  logic [C_M_AXIL_DATA_WIDTH-1:0]     m_axil_rdata,
  input  logic [1:0]                         m_axil_rresp,
  input  logic                               m_axil_rvalid,
  output logic                               m_axil_rready
);

  localparam int unsigned AW    = C_M_AXIL_ADDR_WIDTH;
  localparam int unsigned DW    = C_M_AXIL_DATA_WIDTH;
  localparam int unsigned IdxW  = $clog2(N_REQ);
  localparam int unsigned PollW = $clog2(POLL_INTERVAL + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

  rc_sched_state_t           state_q, state_d;
  logic [IdxW-1:0]           p_q, p_d;
  logic [IdxW-1:0]           g_q, g_d;
  logic [31:0]               addr_q, addr_d;
  logic [BS_LENGTH_BITS-1:0] len_q, len_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      arvalid_q, arvalid_d;
  logic [N_REQ-1:0]          decouple_q, decouple_d;
  logic [PollW-1:0]          poll_cnt_q, poll_cnt_d;
  logic [TmoW-1:0]           tmo_q, tmo_d;

  logic [N_REQ-1:0] arb_grant;
  logic [IdxW-1:0]  arb_idx;
  logic             arb_valid;
  logic             tmo_hit;
  logic             wr_done;
  logic             rd_done;
  logic             unused_rdata;

  rc_rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .req_i  (req),
    .p_i    (p_q),
    .grant_o(arb_grant),
    .idx_o  (arb_idx),
    .valid_o(arb_valid)
  );

  assign tmo_hit      = (tmo_q == TmoW'(TIMEOUT_CYCLES));
  // B/R are only accepted once the request side has fully handshaken.
  assign wr_done      = m_axil_bvalid && !awvalid_q && !wvalid_q;
  assign rd_done      = m_axil_rvalid && !arvalid_q;
  assign unused_rdata = ^m_axil_rdata;

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    g_d        = g_q;
    addr_d     = addr_q;
    len_d      = len_q;
    awvalid_d  = awvalid_q && !m_axil_awready;
    wvalid_d   = wvalid_q && !m_axil_wready;
    arvalid_d  = arvalid_q && !m_axil_arready;
    decouple_d = decouple_q;
    poll_cnt_d = poll_cnt_q;
    tmo_d      = tmo_hit ? tmo_q : tmo_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (|req) state_d = StArb;
      end
      StArb: begin
        if (arb_valid) begin
          g_d        = arb_idx;
          p_d        = (arb_idx == IdxW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          addr_d     = req_addr[32*int'(arb_idx) +: 32];
          len_d      = req_len[BS_LENGTH_BITS*int'(arb_idx) +: BS_LENGTH_BITS];
          decouple_d = decouple_q | arb_grant;
          state_d    = StDecpl;
        end else begin
          state_d = StIdle;
        end
      end
      StDecpl: begin
        if (len_q == '0) begin
          state_d = StFinish;
        end else begin
          state_d   = StWrAddr;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      StWrAddr, StWrLen, StWrStart: begin
        if (wr_done) begin
          if (m_axil_bresp != AXI_RESP_OKAY) begin
            state_d = StFail;
          end else if (state_q == StWrStart) begin
            state_d    = StPollWait;
            poll_cnt_d = '0;
            tmo_d      = '0;
          end else begin
            state_d   = (state_q == StWrAddr) ? StWrLen : StWrStart;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      StPollWait: begin
        if (tmo_hit) begin
          state_d = StFail;
        end else if (poll_cnt_q == PollW'(POLL_INTERVAL - 1)) begin
          state_d   = StPollRd;
          arvalid_d = 1'b1;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
      StPollRd: begin
        if (rd_done) begin
          if (m_axil_rresp != AXI_RESP_OKAY || m_axil_rdata[RC_ST_ERROR]) begin
            state_d = StFail;
          end else if (m_axil_rdata[RC_ST_DONE]) begin
            state_d = StFinish;
          end else if (tmo_hit) begin
            state_d = StFail;
          end else begin
            state_d    = StPollWait;
            poll_cnt_d = '0;
          end
        end
      end
      StFinish: begin
        decouple_d[g_q] = 1'b0;
        state_d         = StIdle;
      end
      StFail: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge AXI_aclk) begin
    if (AXI_areset) begin
      state_q    <= StIdle;
      p_q        <= '0;
      g_q        <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      decouple_q <= '0;
      poll_cnt_q <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      g_q        <= g_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      decouple_q <= decouple_d;
      poll_cnt_q <= poll_cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    m_axil_awaddr = '0;
    m_axil_wdata  = '0;
    m_axil_wstrb  = '0;
    m_axil_bready = 1'b0;
    unique case (state_q)
      StWrAddr: begin
        m_axil_awaddr = AW'(RC_ADDR);
        m_axil_wdata  = DW'(addr_q);
        m_axil_wstrb  = '1;
        m_axil_bready = 1'b1;
      end
      StWrLen: begin
        m_axil_awaddr = AW'(RC_LEN);
        m_axil_wdata  = DW'(len_q);
        m_axil_wstrb  = '1;
        m_axil_bready = 1'b1;
      end
      StWrStart: begin
        m_axil_awaddr = AW'(RC_CTRL);
        m_axil_wdata  = DW'(1);
        m_axil_wstrb  = '1;
        m_axil_bready = 1'b1;
      end
      default: ;
    endcase
  end

  assign m_axil_awprot  = 3'b000;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_araddr  = (state_q == StPollRd) ? AW'(RC_STATUS) : '0;
  assign m_axil_rready  = (state_q == StPollRd);

  assign busy        = (state_q != StIdle);
  assign decouple_rp = decouple_q;
  assign ack         = (state_q == StFinish) ? (N_REQ'(1) << g_q) : '0;
  assign err         = (state_q == StFail) ? (N_REQ'(1) << g_q) : '0;

endmodule

// File: tb/tb_rc_scheduler.sv
// Directed bench for rc_scheduler with a small reactive engine model on the AXI4-Lite port.
module tb_rc_scheduler;

  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 64;
  localparam int unsigned LB  = 24;
  localparam int unsigned PI  = 8;
  localparam int unsigned TMO = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]      req;
  logic [N*32-1:0]   req_addr;
  logic [N*LB-1:0]   req_len;
  logic [N-1:0]      ack, err, dec;
  logic              busy;
  logic [AW-1:0]     awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [DW-1:0]     wdata, rdata;
  logic [DW/8-1:0]   wstrb;
  logic [1:0]        bresp, rresp;

  rc_scheduler #(
    .N_REQ              (N),
    .C_M_AXIL_ADDR_WIDTH(AW),
    .C_M_AXIL_DATA_WIDTH(DW),
    .BS_LENGTH_BITS     (LB),
    .POLL_INTERVAL      (PI),
    .TIMEOUT_CYCLES     (TMO)
  ) dut (
    .AXI_aclk      (clk),
    .AXI_areset    (rst),
    .req           (req),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .ack           (ack),
    .err           (err),
    .busy          (busy),
    .decouple_rp   (dec),
    .m_axil_awaddr (awaddr),
    .m_axil_awprot (awprot),
    .m_axil_awvalid(awvalid),
    .m_axil_awready(awready),
    .m_axil_wdata  (wdata),
    .m_axil_wstrb  (wstrb),
    .m_axil_wvalid (wvalid),
    .m_axil_wready (wready),
    .m_axil_bresp  (bresp),
    .m_axil_bvalid (bvalid),
    .m_axil_bready (bready),
    .m_axil_araddr (araddr),
    .m_axil_arprot (arprot),
    .m_axil_arvalid(arvalid),
    .m_axil_arready(arready),
    .m_axil_rdata  (rdata),
    .m_axil_rresp  (rresp),
    .m_axil_rvalid (rvalid),
    .m_axil_rready (rready)
  );

  // Engine model configuration, written by the stimulus block.
  int            aw_delay = 0;
  int            done_poll = 0;
  int            err_poll = 0;
  logic          bad_en = 1'b0;
  logic [AW-1:0] bad_addr = '0;

  int            aw_wait = 0, poll_num = 0, aw_cnt = 0, w_cnt = 0;
  logic          aw_pend = 1'b0, w_pend = 1'b0, b_done = 1'b0, ar_pend = 1'b0, r_done = 1'b0;
  logic [AW-1:0] cur_awaddr = '0;
  logic [DW-1:0] cur_wdata = '0;
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];

  // Handshakes are observed at the rising edge, slave outputs change at the falling edge.
  always begin
    @(posedge clk);
    if (awvalid && awready) begin aw_cnt++; cur_awaddr = awaddr; aw_pend = 1'b1; end
    if (wvalid && wready) begin w_cnt++; cur_wdata = wdata; w_pend = 1'b1; end
    b_done  = bvalid && bready;
    ar_pend = arvalid && arready;
    r_done  = rvalid && rready;
    @(negedge clk);
    if (rst) begin
      bvalid = 1'b0; rvalid = 1'b0; awready = 1'b0; aw_wait = 0; poll_num = 0;
      aw_pend = 1'b0; w_pend = 1'b0;
    end else begin
      if (b_done) bvalid = 1'b0;
      if (r_done) rvalid = 1'b0;
      if (aw_pend && w_pend) begin
        log_addr.push_back(cur_awaddr);
        log_data.push_back(cur_wdata);
        bvalid = 1'b1;
        bresp  = (bad_en && cur_awaddr == bad_addr) ? 2'b10 : 2'b00;
        if (cur_awaddr == '0) poll_num = 0;
        aw_pend = 1'b0;
        w_pend  = 1'b0;
      end
      if (ar_pend) begin
        poll_num++;
        rvalid   = 1'b1;
        rresp    = 2'b00;
        rdata    = '0;
        rdata[1] = (done_poll > 0 && poll_num >= done_poll);
        rdata[2] = (err_poll > 0 && poll_num == err_poll);
        rdata[0] = !rdata[1];
      end
      if (awvalid) begin
        awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        awready = 1'b0;
        aw_wait = 0;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_req(input int idx, input logic [31:0] a, input logic [LB-1:0] l);
    req_addr[idx*32 +: 32] = a;
    req_len[idx*LB +: LB]  = l;
    req[idx]               = 1'b1;
    repeat (2) @(negedge clk);
    check_eq($sformatf("dec_latency%0d", idx), 64'(dec[idx]), 64'd1);
  endtask

  task automatic wait_done(input int idx, input int limit, output int cyc,
                           output logic [N-1:0] a, output logic [N-1:0] e, output int gaps);
    cyc  = 0;
    a    = '0;
    e    = '0;
    gaps = 0;
    while (cyc < limit && a == '0 && e == '0) begin
      @(negedge clk);
      cyc++;
      if (idx >= 0 && !dec[idx]) gaps++;
      a = ack;
      e = err;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            cyc, gaps, base, abase, wbase, nctrl;
    logic [N-1:0]  a, e, acc;
    logic          seen;

    req = '0; req_addr = '0; req_len = '0;
    wready = 1'b1; arready = 1'b1; awready = 1'b0;
    bvalid = 1'b0; bresp = '0; rvalid = 1'b0; rresp = '0; rdata = '0;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", 64'({ack, err, dec, busy, awvalid, wvalid, arvalid, bready, rready}), 0);
    check_eq("prot", 64'({awprot, arprot}), 0);
    rst = 1'b0;

    // Single request on partition 1, done on third poll
    done_poll = 3;
    base = log_addr.size();
    req_addr[32 +: 32] = 32'h1000_0000;
    req_len[LB +: LB]  = 24'h4000;
    req[1] = 1'b1;
    @(negedge clk);
    check_eq("t1_busy", 64'(busy), 1);
    check_eq("t1_dec_early", 64'(dec), 0);
    @(negedge clk);
    check_eq("t1_dec_lat", 64'(dec), 64'h2);
    wait_done(1, 1000, cyc, a, e, gaps);
    check_eq("t1_ack", 64'(a), 64'h2);
    check_eq("t1_err", 64'(e), 0);
    check_eq("t1_dec_gaps", 64'(gaps), 0);
    req[1] = 1'b0;
    @(negedge clk);
    check_eq("t1_ack_width", 64'(ack), 0);
    check_eq("t1_dec_off", 64'(dec), 0);
    check_eq("t1_nwr", 64'(log_addr.size() - base), 3);
    check_eq("t1_wa0", 64'(log_addr[base]), 64'h08);
    check_eq("t1_wd0", log_data[base], 64'h1000_0000);
    check_eq("t1_wa1", 64'(log_addr[base+1]), 64'h10);
    check_eq("t1_wd1", log_data[base+1], 64'h4000);
    check_eq("t1_wa2", 64'(log_addr[base+2]), 64'h00);
    check_eq("t1_wd2", log_data[base+2], 64'h1);
    check_eq("t1_polls", 64'(poll_num), 3);

    // Fairness with all four requests held
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    done_poll = 1;
    for (int i = 0; i < N; i++) begin
      req_addr[i*32 +: 32] = 32'h2000_0000 + 32'(i);
      req_len[i*LB +: LB]  = 24'h100;
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(-1, 500, cyc, a, e, gaps);
      check_eq($sformatf("fair%0d", k), 64'(a), 64'(1) << (k % 4));
    end
    req = '0;
    repeat (3) @(negedge clk);

    // Engine reports error on the first poll
    done_poll = 0;
    err_poll  = 1;
    start_req(2, 32'h3000_0000, 24'h800);
    wait_done(2, 500, cyc, a, e, gaps);
    check_eq("er_err", 64'(e), 64'h4);
    check_eq("er_ack", 64'(a), 0);
    req[2] = 1'b0;
    acc = '0;
    repeat (5) begin
      @(negedge clk);
      acc |= ack;
    end
    check_eq("er_no_ack", 64'(acc), 0);
    check_eq("er_dec_hold", 64'(dec[2]), 1);
    err_poll = 0;

    // Slave error on the LEN write
    done_poll = 1;
    bad_en    = 1'b1;
    bad_addr  = 5'h10;
    base  = log_addr.size();
    abase = aw_cnt;
    start_req(3, 32'h4000_0000, 24'h80);
    wait_done(3, 500, cyc, a, e, gaps);
    check_eq("se_err", 64'(e), 64'h8);
    check_eq("se_ack", 64'(a), 0);
    req[3] = 1'b0;
    repeat (3) @(negedge clk);
    nctrl = 0;
    for (int i = base; i < log_addr.size(); i++) if (log_addr[i] == '0) nctrl++;
    check_eq("se_no_ctrl", 64'(nctrl), 0);
    check_eq("se_aw_cnt", 64'(aw_cnt - abase), 2);
    bad_en = 1'b0;

    // Timeout: done never set
    done_poll = 0;
    start_req(0, 32'h5000_0000, 24'h200);
    wait_done(0, 3000, cyc, a, e, gaps);
    check_eq("to_err", 64'(e), 64'h1);
    check_eq("to_ack", 64'(a), 0);
    check_eq("to_window", 64'((cyc + 2 >= 1000) && (cyc + 2 <= 1030)), 1);
    req[0] = 1'b0;
    done_poll = 1;
    @(negedge clk);
    start_req(1, 32'h5100_0000, 24'h20);
    wait_done(1, 500, cyc, a, e, gaps);
    check_eq("to_next_ack", 64'(a), 64'h2);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);

    // AW backpressure
    aw_delay = 5;
    base  = log_addr.size();
    abase = aw_cnt;
    wbase = w_cnt;
    start_req(2, 32'hABCD_0000, 24'h10);
    wait_done(2, 500, cyc, a, e, gaps);
    check_eq("bp_ack", 64'(a), 64'h4);
    check_eq("bp_aw_cnt", 64'(aw_cnt - abase), 3);
    check_eq("bp_w_cnt", 64'(w_cnt - wbase), 3);
    check_eq("bp_wd0", log_data[base], 64'hABCD_0000);
    check_eq("bp_wd1", log_data[base+1], 64'h10);
    req[2] = 1'b0;
    aw_delay = 0;
    repeat (2) @(negedge clk);

    // Reset while a status read is outstanding
    done_poll = 0;
    start_req(1, 32'h6000_0000, 24'h40);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = arvalid;
    end
    check_eq("rr_reached", 64'(seen), 1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check_eq("rr_outs", 64'({ack, err, dec, busy, awvalid, wvalid, arvalid, bready, rready}), 0);
    rst = 1'b0;
    done_poll = 1;
    req = 4'b1010;
    repeat (2) @(negedge clk);
    check_eq("rr_p_reset", 64'(dec), 64'h2);
    wait_done(1, 500, cyc, a, e, gaps);
    check_eq("rr_ack", 64'(a), 64'h2);
    req = '0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
